truco_aposta_ctrl: RTL
======================

Name: truco_aposta_ctrl

Overview:
Bet/stake controller for the truco scoreboard; sits between the debounced player buttons and placar_truco.
- Runs the per-hand stake ladder 1 → 3 → 6 → 9 → 12.
- Arbitrates simultaneous raise requests from teams A and B.
- Handles accept, fold and re-raise responses, with a response timeout.
- Emits one-cycle score-increment pulses carrying the points value to the scoreboard.

Parameters:
TIMEOUT_CICLOS, 50_000_000, cycles to wait for a response before treating it as a fold; counter width = $clog2(TIMEOUT_CICLOS+1).
VALOR_MAX, 12, top of the stake ladder; raises at this value are ignored.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-low (rst=0 at a rising clk edge resets all state).
pede_A, pede_B  in  1  raise request (truco/seis/nove/doze), one-cycle debounced pulse.
aceita_A, aceita_B  in  1  accept pending raise, one-cycle pulse.
corre_A, corre_B  in  1  fold on pending raise, one-cycle pulse.
fim_mao_A, fim_mao_B  in  1  hand won by A/B, one-cycle pulse.
jogo_encerrado  in  1  level from scoreboard; game over.
valor_aposta  out  4  current accepted stake of the hand.
proposta  out  4  pending proposed stake; 0 when none.
aguardando  out  1  high while a raise awaits a response.
quem_pediu  out  1  team of the pending or last accepted raise (0=A, 1=B).
inc_A, inc_B  out  1  one-cycle award pulse; never both high.
pontos_out  out  4  points to add; valid only while inc_A or inc_B is high, else 0.

Behaviour:
Reset values:
- valor_aposta=1, proposta=0, aguardando=0, quem_pediu=0.
- inc_A=inc_B=0, pontos_out=0.
- State OCIOSO, round-robin priority on A, timeout counter 0, no raise lock.

Stake ladder: 1 → 3 → 6 → 9 → 12 (next-value function). After each accepted raise only the opposing team may raise next (lock). The lock clears when a hand ends.

FSM states: OCIOSO, AGUARDA, PREMIA, BLOQUEADO.

OCIOSO (hand in play):
- Valid raise = pede_X with X not locked and valor_aposta < VALOR_MAX. It sets proposta = next(valor_aposta), quem_pediu=X, aguardando=1, clears the counter and goes to AGUARDA on the next edge.
- pede_A and pede_B in the same cycle, both valid: the round-robin arbiter grants the team not granted last time (A first after reset). The loser's request is dropped.
- fim_mao_X alone: award valor_aposta to X and go to PREMIA.
- fim_mao_A and fim_mao_B together: ignore both.
- Raise and fim_mao in the same cycle: fim_mao wins; the raise is dropped.

AGUARDA (only the responder Y = not quem_pediu is heard):
- aceita_Y: valor_aposta = proposta, proposta=0, aguardando=0, lock Y's opponent (raise X), go to OCIOSO.
- pede_Y: counts as acceptance. valor_aposta = proposta; if that is < VALOR_MAX, proposta = next(it), quem_pediu=Y, counter cleared, stay in AGUARDA. Otherwise behave as aceita_Y.
- corre_Y, or counter reaching TIMEOUT_CICLOS-1 with no response: award the old valor_aposta (pre-raise) to quem_pediu, go to PREMIA.
- Same-cycle priority: corre_Y > pede_Y > aceita_Y.
- Inputs from team X, and all fim_mao, are ignored in this state.
- Counter increments every cycle in AGUARDA.

PREMIA (exactly 1 cycle):
- inc of the winner = 1, pontos_out = awarded value.
- Next edge: valor_aposta=1, proposta=0, aguardando=0, lock cleared, go to OCIOSO.

Latency: award pulse appears on the cycle after the deciding input edge.

jogo_encerrado=1:
- From any state go to BLOQUEADO on the next edge; a pending raise is discarded.
- If jogo_encerrado rises while in PREMIA, that pulse still completes.
- BLOQUEADO: outputs held at reset values, all inputs ignored; exit only via rst=0.

Reset asserted mid-operation: all state returns to reset values on that edge; no award pulse is emitted.

Decomposition:
- truco_pkg: state enum, the ladder constants (1, 3, 6, 9, 12), function proximo_valor(logic[3:0]) returning logic[3:0], team encoding constants EQ_A=0, EQ_B=1.
- One sub-module, arbitro_rr2: a 2-requester round-robin arbiter with the same clk/rst, with req[1:0] in and one-hot gnt[1:0] out. Its priority pointer updates only on a grant.

Test Plan:
- Reset, then fim_mao_A → one cycle later inc_A=1, pontos_out=1; valor_aposta returns to 1.
- pede_A, aceita_B, pede_B, aceita_A, then fim_mao_B → valor_aposta 3 then 6; inc_B pulse with pontos_out=6.
- pede_A then corre_B → inc_A with pontos_out=1. Repeat with valor 9 and pede_B/corre_A → inc_B with pontos_out=9.
- pede_A & pede_B same cycle twice (each resolved by aceita) → first grant A (quem_pediu=0), second grant B; a re-raise by A while locked is ignored.
- With TIMEOUT_CICLOS=8: pede_B, no response → inc_B, pontos_out=1 at cycle 8+1; re-raise chain to 12, then pede is ignored and proposta stays 0.
- Assert jogo_encerrado during AGUARDA → BLOQUEADO, no inc pulses despite button activity; rst=0 for one edge → valor_aposta=1, OCIOSO.

Source files
------------

// File: rtl/truco_pkg.sv
// Shared definitions for the truco stake controller.
//   estado_t       : controller FSM states
//   VALOR_*        : rungs of the per-hand stake ladder
//   EQ_A / EQ_B    : team encoding used on quem_pediu and internal team fields
//   proximo_valor  : next rung of the ladder (saturates at 12)
package truco_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        AGUARDA   = 2'd1,
        PREMIA    = 2'd2,
        BLOQUEADO = 2'd3
    } estado_t;

    localparam logic [3:0] VALOR_1  = 4'd1;
    localparam logic [3:0] VALOR_3  = 4'd3;
    localparam logic [3:0] VALOR_6  = 4'd6;
    localparam logic [3:0] VALOR_9  = 4'd9;
    localparam logic [3:0] VALOR_12 = 4'd12;

    localparam logic EQ_A = 1'b0;
    localparam logic EQ_B = 1'b1;

    function automatic logic [3:0] proximo_valor(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            VALOR_1: r = VALOR_3;
            VALOR_3: r = VALOR_6;
            VALOR_6: r = VALOR_9;
            default: r = VALOR_12;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arbitro_rr2.sv
// Two-requester round-robin arbiter.
//   clk     : system clock
//   rst     : synchronous reset, active-low (priority returns to requester 0)
//   req[1:0]: request lines (bit 0 = team A, bit 1 = team B)
//   gnt[1:0]: one-hot grant, combinational from req and the priority pointer
// The pointer only moves when a grant is issued, so idle cycles keep the
// current priority.
module arbitro_rr2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 1: requester 1 wins a tie next time; 0: requester 0 wins.
    logic prio_b_reg;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio_b_reg ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_b_reg <= 1'b0;
        end else if (gnt != 2'b00) begin
            // whoever was just served yields the tie-break
            prio_b_reg <= gnt[0];
        end
    end

endmodule

// File: rtl/truco_aposta_ctrl.sv
// Stake controller between the debounced player buttons and the scoreboard.
//   clk, rst            : clock, synchronous active-low reset
//   pede_A/B            : raise request pulses
//   aceita_A/B          : accept pulses for a pending raise
//   corre_A/B           : fold pulses for a pending raise
//   fim_mao_A/B         : hand-won pulses
//   jogo_encerrado      : game-over level; freezes the controller until reset
//   valor_aposta        : accepted stake of the current hand
//   proposta            : pending proposed stake, 0 when nothing is pending
//   aguardando          : a raise is waiting for an answer
//   quem_pediu          : team of the pending / last accepted raise
//   inc_A, inc_B        : one-cycle award pulses
//   pontos_out          : points carried by the award pulse, else 0
module truco_aposta_ctrl
    import truco_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = 50_000_000,
    parameter int unsigned VALOR_MAX      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pede_A,
    input  logic       pede_B,
    input  logic       aceita_A,
    input  logic       aceita_B,
    input  logic       corre_A,
    input  logic       corre_B,
    input  logic       fim_mao_A,
    input  logic       fim_mao_B,
    input  logic       jogo_encerrado,
    output logic [3:0] valor_aposta,
    output logic [3:0] proposta,
    output logic       aguardando,
    output logic       quem_pediu,
    output logic       inc_A,
    output logic       inc_B,
    output logic [3:0] pontos_out
);

    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [CW-1:0] LIMITE     = CW'(TIMEOUT_CICLOS - 1);
    localparam logic [3:0]    VALOR_TOPO = 4'(VALOR_MAX);

    estado_t       estado_reg, estado_next;
    logic [3:0]    valor_reg, valor_next;
    logic [3:0]    proposta_reg, proposta_next;
    logic          quem_reg, quem_next;
    logic [CW-1:0] cont_reg, cont_next;
    logic          lock_valid_reg, lock_valid_next;   // a team is barred from raising
    logic          lock_team_reg, lock_team_next;     // which team is barred
    logic          premio_team_reg, premio_team_next;
    logic [3:0]    premio_pts_reg, premio_pts_next;

    logic [1:0] pede_vec;
    logic [1:0] pede_ok;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       valor_abaixo_max;

    assign pede_vec         = {pede_B, pede_A};
    assign valor_abaixo_max = (valor_reg < VALOR_TOPO);

    // Per-team raise qualification: not locked out and ladder not exhausted.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pede
            assign pede_ok[gi] = pede_vec[gi] && valor_abaixo_max &&
                                 !(lock_valid_reg && (lock_team_reg == 1'(gi)));
        end
    endgenerate

    // Only raises that will really open a proposal reach the arbiter, so
    // the round-robin pointer tracks actual grants. Any fim_mao drops them.
    always_comb begin
        req = 2'b00;
        if (estado_reg == OCIOSO && !jogo_encerrado && !fim_mao_A && !fim_mao_B) begin
            req = pede_ok;
        end
    end

    arbitro_rr2 u_arbitro (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    // Responder view: only the team opposite to quem_pediu is heard.
    logic corre_y, pede_y, aceita_y;
    assign corre_y  = (quem_reg == EQ_A) ? corre_B  : corre_A;
    assign pede_y   = (quem_reg == EQ_A) ? pede_B   : pede_A;
    assign aceita_y = (quem_reg == EQ_A) ? aceita_B : aceita_A;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            estado_reg      <= OCIOSO;
            valor_reg       <= VALOR_1;
            proposta_reg    <= 4'd0;
            quem_reg        <= EQ_A;
            cont_reg        <= '0;
            lock_valid_reg  <= 1'b0;
            lock_team_reg   <= EQ_A;
            premio_team_reg <= EQ_A;
            premio_pts_reg  <= 4'd0;
        end else begin
            estado_reg      <= estado_next;
            valor_reg       <= valor_next;
            proposta_reg    <= proposta_next;
            quem_reg        <= quem_next;
            cont_reg        <= cont_next;
            lock_valid_reg  <= lock_valid_next;
            lock_team_reg   <= lock_team_next;
            premio_team_reg <= premio_team_next;
            premio_pts_reg  <= premio_pts_next;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        estado_next      = estado_reg;
        valor_next       = valor_reg;
        proposta_next    = proposta_reg;
        quem_next        = quem_reg;
        cont_next        = cont_reg;
        lock_valid_next  = lock_valid_reg;
        lock_team_next   = lock_team_reg;
        premio_team_next = premio_team_reg;
        premio_pts_next  = premio_pts_reg;

        case (estado_reg)
            OCIOSO: begin
                if (fim_mao_A ^ fim_mao_B) begin
                    premio_team_next = fim_mao_B ? EQ_B : EQ_A;
                    premio_pts_next  = valor_reg;
                    estado_next      = PREMIA;
                end else if (gnt != 2'b00) begin
                    proposta_next = proximo_valor(valor_reg);
                    quem_next     = gnt[1] ? EQ_B : EQ_A;
                    cont_next     = '0;
                    estado_next   = AGUARDA;
                end
            end

            AGUARDA: begin
                cont_next = cont_reg + CW'(1);
                if (corre_y) begin
                    // fold: the raiser takes the stake that stood before the raise
                    premio_team_next = quem_reg;
                    premio_pts_next  = valor_reg;
                    proposta_next    = 4'd0;
                    estado_next      = PREMIA;
                end else if (pede_y && (proposta_reg < VALOR_TOPO)) begin
                    // re-raise: accept the current proposal and counter-propose
                    valor_next    = proposta_reg;
                    proposta_next = proximo_valor(proposta_reg);
                    quem_next     = ~quem_reg;
                    cont_next     = '0;
                end else if (pede_y || aceita_y) begin
                    valor_next      = proposta_reg;
                    proposta_next   = 4'd0;
                    lock_valid_next = 1'b1;
                    lock_team_next  = quem_reg;
                    estado_next     = OCIOSO;
                end else if (cont_reg == LIMITE) begin
                    premio_team_next = quem_reg;
                    premio_pts_next  = valor_reg;
                    proposta_next    = 4'd0;
                    estado_next      = PREMIA;
                end
            end

            PREMIA: begin
                valor_next      = VALOR_1;
                proposta_next   = 4'd0;
                lock_valid_next = 1'b0;
                estado_next     = OCIOSO;
            end

            default: begin
                estado_next = BLOQUEADO;
            end
        endcase

        // Game over overrides everything; the award already on the outputs
        // this cycle (if in PREMIA) is unaffected because outputs are registered state.
        if (jogo_encerrado) begin
            estado_next     = BLOQUEADO;
            valor_next      = VALOR_1;
            proposta_next   = 4'd0;
            quem_next       = EQ_A;
            cont_next       = '0;
            lock_valid_next = 1'b0;
            lock_team_next  = EQ_A;
        end
    end

    // Output logic
    always_comb begin
        valor_aposta = valor_reg;
        proposta     = proposta_reg;
        aguardando   = (estado_reg == AGUARDA);
        quem_pediu   = quem_reg;
        inc_A        = 1'b0;
        inc_B        = 1'b0;
        pontos_out   = 4'd0;
        if (estado_reg == PREMIA) begin
            inc_A      = (premio_team_reg == EQ_A);
            inc_B      = (premio_team_reg == EQ_B);
            pontos_out = premio_pts_reg;
        end
    end

endmodule
